riot6532: RTL and testbench

- Parametrised successor to the simple Atari 2600 PIA: a fuller 6532 RIOT model.
- Provides two 8-bit I/O ports with data-direction registers, and an interval timer with four selectable prescalers.
- Timer advances on a CPU-cycle enable rather than every clock. Adds PA7 edge detection, interrupt flags/enables and an IRQ output.
- Sits on the CPU bus beside the TIA. Joystick/console switches connect to pa_i/pb_i.

---
 rtl/riot_pkg.sv | 54 +++++
 rtl/riot_timer.sv | 95 +++++++++
 rtl/riot6532.sv | 157 +++++++++++++++
 tb/tb_riot6532.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riot_pkg.sv
//==============================================================================
// Module      : riot_pkg
// Description : Shared register map, prescaler defaults and button bit indices
//               for the 6532 RIOT model.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package riot_pkg;

    // Register map
    localparam logic [6:0] SWCHA     = 7'h00;
    localparam logic [6:0] SWACNT    = 7'h01;
    localparam logic [6:0] SWCHB     = 7'h02;
    localparam logic [6:0] SWBCNT    = 7'h03;
    localparam logic [6:0] INTIM     = 7'h04;
    localparam logic [6:0] INSTAT    = 7'h05;
    localparam logic [6:0] INTIM_IE  = 7'h0C;
    localparam logic [6:0] INSTAT_IE = 7'h0D;
    localparam logic [6:0] EDGE_BASE = 7'h04;
    localparam logic [6:0] EDGE_MASK = 7'h7C;
    localparam logic [6:0] TIM_BASE  = 7'h14;
    localparam logic [6:0] TIM_MASK  = 7'h74;

    // Default log2 prescale for interval selects 1..3
    localparam int PS_SHIFT1_DEF = 3;
    localparam int PS_SHIFT2_DEF = 6;
    localparam int PS_SHIFT3_DEF = 10;

    // Joystick / console switch bit positions on pa_i / pb_i
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_UP     = 4;
    localparam int BTN_FIRE   = 3;
    localparam int BTN_SELECT = 1;
    localparam int BTN_RESET  = 0;

    typedef enum logic [1:0] {
        SEL_1    = 2'd0,
        SEL_8    = 2'd1,
        SEL_64   = 2'd2,
        SEL_1024 = 2'd3
    } tsel_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/riot_timer.sv
//==============================================================================
// Module      : riot_timer
// Description : Interval timer: prescaler, 8-bit down counter, underflow mode
//               and timer interrupt flag, advanced by a CPU-cycle enable.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module riot_timer
    import riot_pkg::*;
#(
    parameter int PS_SHIFT1 = PS_SHIFT1_DEF,
    parameter int PS_SHIFT2 = PS_SHIFT2_DEF,
    parameter int PS_SHIFT3 = PS_SHIFT3_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ce,
    input  logic       load,
    input  logic [1:0] sel,
    input  logic [7:0] load_val,
    input  logic       rd_clr,
    output logic [7:0] timer,
    output logic       tflag
);

    localparam int PW_RAW = max3(PS_SHIFT1, PS_SHIFT2, PS_SHIFT3);
    localparam int PW     = (PW_RAW > 0) ? PW_RAW : 1;

    localparam logic [PW-1:0] LIM1 = PW'((1 << PS_SHIFT1) - 1);
    localparam logic [PW-1:0] LIM2 = PW'((1 << PS_SHIFT2) - 1);
    localparam logic [PW-1:0] LIM3 = PW'((1 << PS_SHIFT3) - 1);

    logic [PW-1:0] r_pre;
    logic [7:0]    r_timer;
    tsel_e         r_sel;
    logic          r_uflow;
    logic          r_tflag;

    logic [PW-1:0] w_limit;
    logic          w_tick;
    logic          w_zero_tick;

    always_comb begin
        w_limit = '0;
        case (r_sel)
            SEL_8:    w_limit = LIM1;
            SEL_64:   w_limit = LIM2;
            SEL_1024: w_limit = LIM3;
            default:  w_limit = '0;
        endcase
    end

    // Once underflowed the counter ticks on every enabled cycle
    assign w_tick      = ce && (r_uflow || (r_pre == w_limit));
    assign w_zero_tick = w_tick && (r_timer == 8'h00);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pre   <= '0;
            r_timer <= 8'h00;
            r_sel   <= SEL_1024;
            r_uflow <= 1'b0;
            r_tflag <= 1'b0;
        end else if (load) begin
            r_pre   <= '0;
            r_timer <= load_val;
            r_sel   <= tsel_e'(sel);
            r_uflow <= 1'b0;
            r_tflag <= 1'b0;
        end else begin
            if (ce) begin
                if (w_tick) begin
                    r_pre   <= '0;
                    r_timer <= r_timer - 8'd1;
                    if (r_timer == 8'h00)
                        r_uflow <= 1'b1;
                end else begin
                    r_pre <= r_pre + PW'(1);
                end
            end
            // An underflow in the same cycle as a read-clear still flags
            if (w_zero_tick)
                r_tflag <= 1'b1;
            else if (rd_clr)
                r_tflag <= 1'b0;
        end
    end

    assign timer = r_timer;
    assign tflag = r_tflag;

endmodule

`default_nettype wire

// File: rtl/riot6532.sv
//==============================================================================
// Module      : riot6532
// Description : 6532 RIOT: two I/O ports with direction registers, interval
//               timer, PA7 edge detector and interrupt logic on a CPU bus.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module riot6532
    import riot_pkg::*;
#(
    parameter int         PS_SHIFT1 = PS_SHIFT1_DEF,
    parameter int         PS_SHIFT2 = PS_SHIFT2_DEF,
    parameter int         PS_SHIFT3 = PS_SHIFT3_DEF,
    parameter logic [7:0] DDRA_RST  = 8'h00,
    parameter logic [7:0] DDRB_RST  = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ce_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [6:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    input  logic [7:0] pa_i,
    input  logic [7:0] pb_i,
    output logic [7:0] pa_o,
    output logic [7:0] pb_o,
    output logic [7:0] pa_oe,
    output logic [7:0] pb_oe,
    output logic       irq_o,
    output logic [7:0] diag
);

    logic [7:0] r_ora;
    logic [7:0] r_orb;
    logic [7:0] r_ddra;
    logic [7:0] r_ddrb;
    logic       r_tie;
    logic       r_eie;
    logic       r_pol;
    logic       r_eflag;
    logic       r_pa7;

    logic       w_valid;
    logic       w_rd;
    logic       w_wr;
    logic       w_timer_rd;
    logic       w_stat_rd;
    logic       w_edge_wr;
    logic       w_load;
    logic       w_edge;
    logic       w_rd_hit;
    logic [7:0] w_rd_data;
    logic [7:0] w_timer;
    logic       w_tflag;

    assign w_valid    = stb_i & ~rst_i;
    assign w_rd       = w_valid & ~we_i;
    assign w_wr       = w_valid & we_i;
    assign w_timer_rd = w_rd && ((adr_i == INTIM) || (adr_i == INTIM_IE));
    assign w_stat_rd  = w_rd && ((adr_i == INSTAT) || (adr_i == INSTAT_IE));
    assign w_edge_wr  = w_wr && ((adr_i & EDGE_MASK) == EDGE_BASE);
    assign w_load     = w_wr && ((adr_i & TIM_MASK) == TIM_BASE);

    riot_timer #(
        .PS_SHIFT1 (PS_SHIFT1),
        .PS_SHIFT2 (PS_SHIFT2),
        .PS_SHIFT3 (PS_SHIFT3)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ce       (ce_i),
        .load     (w_load),
        .sel      (adr_i[1:0]),
        .load_val (dat_i),
        .rd_clr   (w_timer_rd),
        .timer    (w_timer),
        .tflag    (w_tflag)
    );

    always_comb begin
        w_rd_hit  = 1'b1;
        w_rd_data = 8'h00;
        case (adr_i)
            SWCHA:             w_rd_data = (pa_i & ~r_ddra) | (r_ora & r_ddra);
            SWACNT:            w_rd_data = r_ddra;
            SWCHB:             w_rd_data = (pb_i & ~r_ddrb) | (r_orb & r_ddrb);
            SWBCNT:            w_rd_data = r_ddrb;
            INTIM, INTIM_IE:   w_rd_data = w_timer;
            INSTAT, INSTAT_IE: w_rd_data = {w_tflag, r_eflag, 6'b0};
            default:           w_rd_hit  = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            dat_o <= 8'h00;
        else if (w_rd && w_rd_hit)
            dat_o <= w_rd_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ora  <= 8'h00;
            r_orb  <= 8'h00;
            r_ddra <= DDRA_RST;
            r_ddrb <= DDRB_RST;
            r_tie  <= 1'b0;
            r_eie  <= 1'b0;
            r_pol  <= 1'b0;
        end else begin
            if (w_wr) begin
                case (adr_i)
                    SWCHA:   r_ora  <= dat_i;
                    SWACNT:  r_ddra <= dat_i;
                    SWCHB:   r_orb  <= dat_i;
                    SWBCNT:  r_ddrb <= dat_i;
                    default: ;
                endcase
            end
            if (w_edge_wr) begin
                r_pol <= adr_i[0];
                r_eie <= adr_i[1];
            end
            if (w_load || w_timer_rd)
                r_tie <= adr_i[3];
        end
    end

    // PA7 is sampled every clock so the edge history survives reset cleanly
    always_ff @(posedge clk_i) begin
        r_pa7 <= pa_i[7];
    end

    assign w_edge = r_pol ? (~r_pa7 & pa_i[7]) : (r_pa7 & ~pa_i[7]);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_eflag <= 1'b0;
        else if (w_edge)
            r_eflag <= 1'b1;
        else if (w_stat_rd)
            r_eflag <= 1'b0;
    end

    assign pa_o  = r_ora;
    assign pb_o  = r_orb;
    assign pa_oe = r_ddra;
    assign pb_oe = r_ddrb;
    assign irq_o = (w_tflag & r_tie) | (r_eflag & r_eie);
    assign diag  = w_timer;

endmodule

`default_nettype wire

// File: tb/tb_riot6532.sv
//==============================================================================
// Module      : tb_riot6532
// Description : Directed and randomized bench for riot6532 with a behavioural
//               reference model based on elapsed enable counts.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_riot6532;

    localparam logic [7:0] DDRA_R = 8'h0F;
    localparam logic [7:0] DDRB_R = 8'h00;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       ce_i = 1'b0;
    logic       stb_i = 1'b0;
    logic       we_i = 1'b0;
    logic [6:0] adr_i = '0;
    logic [7:0] dat_i = '0;
    logic [7:0] pa_i = '0;
    logic [7:0] pb_i = '0;
    logic [7:0] dat_o, pa_o, pb_o, pa_oe, pb_oe, diag;
    logic       irq_o;

    riot6532 #(
        .DDRA_RST (DDRA_R),
        .DDRB_RST (DDRB_R)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .ce_i  (ce_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .pa_i  (pa_i),
        .pb_i  (pb_i),
        .pa_o  (pa_o),
        .pb_o  (pb_o),
        .pa_oe (pa_oe),
        .pb_oe (pb_oe),
        .irq_o (irq_o),
        .diag  (diag)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int ce_mode = 0;
    int cyc     = 0;

    // Reference state: timer is described by load value, select and the
    // number of enabled cycles elapsed since the load.
    logic [7:0] m_ora, m_orb, m_ddra, m_ddrb, m_v, m_dat;
    logic [1:0] m_sel;
    int         m_n;
    logic       m_tflag, m_eflag, m_tie, m_eie, m_pol, m_prev;

    function automatic int period(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 8;
            2'd2:    return 64;
            default: return 1024;
        endcase
    endfunction

    function automatic logic [7:0] tval(input logic [7:0] v, input logic [1:0] s, input int n);
        int p, u;
        p = period(s);
        u = (int'(v) + 1) * p;
        if (n < u) return 8'(int'(v) - n / p);
        return 8'(255 - ((n - u) % 256));
    endfunction

    function automatic logic zero_hit(input logic [7:0] v, input logic [1:0] s, input int n);
        int u;
        u = (int'(v) + 1) * period(s);
        return (n >= u) && (((n - u) % 256) == 0);
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        logic [7:0] n_ora, n_orb, n_ddra, n_ddrb, n_v, n_dat;
        logic [1:0] n_sel;
        int         n_n;
        logic       n_tflag, n_eflag, n_tie, n_eie, n_pol;
        logic       rd, wr, ld, trd, srd, edge_ev;
        cyc++;
        case (ce_mode)
            0:       ce_i = 1'b1;
            1:       ce_i = ((cyc % 3) == 0);
            default: ce_i = 1'($urandom_range(0, 1));
        endcase
        if (rst_i) begin
            n_ora = 8'h00; n_orb = 8'h00; n_ddra = DDRA_R; n_ddrb = DDRB_R;
            n_v = 8'h00; n_sel = 2'd3; n_n = 0; n_dat = 8'h00;
            n_tflag = 1'b0; n_eflag = 1'b0; n_tie = 1'b0; n_eie = 1'b0; n_pol = 1'b0;
        end else begin
            n_ora = m_ora; n_orb = m_orb; n_ddra = m_ddra; n_ddrb = m_ddrb;
            n_v = m_v; n_sel = m_sel; n_n = m_n; n_dat = m_dat;
            n_tflag = m_tflag; n_eflag = m_eflag; n_tie = m_tie; n_eie = m_eie; n_pol = m_pol;
            rd  = stb_i && !we_i;
            wr  = stb_i && we_i;
            ld  = wr && (adr_i inside {[7'h14:7'h17], [7'h1C:7'h1F]});
            trd = rd && (adr_i == 7'h04 || adr_i == 7'h0C);
            srd = rd && (adr_i == 7'h05 || adr_i == 7'h0D);
            edge_ev = m_pol ? (!m_prev && pa_i[7]) : (m_prev && !pa_i[7]);
            if (rd) begin
                case (adr_i)
                    7'h00:        n_dat = (pa_i & ~m_ddra) | (m_ora & m_ddra);
                    7'h01:        n_dat = m_ddra;
                    7'h02:        n_dat = (pb_i & ~m_ddrb) | (m_orb & m_ddrb);
                    7'h03:        n_dat = m_ddrb;
                    7'h04, 7'h0C: n_dat = tval(m_v, m_sel, m_n);
                    7'h05, 7'h0D: n_dat = {m_tflag, m_eflag, 6'b0};
                    default:      ;
                endcase
            end
            if (wr) begin
                case (adr_i)
                    7'h00: n_ora  = dat_i;
                    7'h01: n_ddra = dat_i;
                    7'h02: n_orb  = dat_i;
                    7'h03: n_ddrb = dat_i;
                    7'h04, 7'h05, 7'h06, 7'h07: begin
                        n_pol = adr_i[0];
                        n_eie = adr_i[1];
                    end
                    default: ;
                endcase
            end
            if (trd) n_tie = adr_i[3];
            if (ld) begin
                n_v = dat_i; n_sel = adr_i[1:0]; n_n = 0; n_tflag = 1'b0; n_tie = adr_i[3];
            end else begin
                if (ce_i) n_n = m_n + 1;
                if (ce_i && zero_hit(m_v, m_sel, m_n + 1)) n_tflag = 1'b1;
                else if (trd) n_tflag = 1'b0;
            end
            if (edge_ev) n_eflag = 1'b1;
            else if (srd) n_eflag = 1'b0;
        end
        @(posedge clk);
        #1;
        m_prev = pa_i[7];
        m_ora = n_ora; m_orb = n_orb; m_ddra = n_ddra; m_ddrb = n_ddrb;
        m_v = n_v; m_sel = n_sel; m_n = n_n; m_dat = n_dat;
        m_tflag = n_tflag; m_eflag = n_eflag; m_tie = n_tie; m_eie = n_eie; m_pol = n_pol;
        chk("dat_o", dat_o, m_dat);
        chk("diag", diag, tval(m_v, m_sel, m_n));
        chk("irq_o", {7'b0, irq_o}, {7'b0, (m_tflag & m_tie) | (m_eflag & m_eie)});
        chk("pa_o", pa_o, m_ora);
        chk("pb_o", pb_o, m_orb);
        chk("pa_oe", pa_oe, m_ddra);
        chk("pb_oe", pb_oe, m_ddrb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bus(input logic w, input logic [6:0] a, input logic [7:0] d);
        stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
        cycle();
        stb_i = 1'b0; we_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst_i = 1'b1;
        idle(2);
        chk("rst_diag", diag, 8'h00);
        chk("rst_dat", dat_o, 8'h00);
        chk("rst_irq", {7'b0, irq_o}, 8'h00);
        chk("rst_pa_oe", pa_oe, DDRA_R);
        chk("rst_pa_o", pa_o, 8'h00);
        rst_i = 1'b0;

        // Port mixing
        ce_mode = 0;
        bus(1'b1, 7'h01, 8'hF0);
        bus(1'b1, 7'h00, 8'hA5);
        pa_i = 8'h3C;
        bus(1'b0, 7'h00, 8'h00);
        chk("porta_rd", dat_o, 8'hAC);
        chk("porta_oe", pa_oe, 8'hF0);
        chk("porta_o", pa_o, 8'hA5);
        bus(1'b1, 7'h03, 8'h0F);
        bus(1'b1, 7'h02, 8'h5A);
        pb_i = 8'hC3;
        bus(1'b0, 7'h02, 8'h00);
        chk("portb_rd", dat_o, 8'hCA);
        bus(1'b0, 7'h7F, 8'h00);
        chk("unmapped_rd_hold", dat_o, 8'hCA);

        // 64-cycle interval, continuous enable
        bus(1'b1, 7'h16, 8'h02);
        idle(64);
        chk("t64_a", diag, 8'h01);
        idle(64);
        chk("t64_b", diag, 8'h00);
        idle(64);
        chk("t64_wrap", diag, 8'hFF);
        idle(1);
        chk("t64_fast", diag, 8'hFE);
        bus(1'b0, 7'h05, 8'h00);
        chk("t64_stat", dat_o, 8'h80);

        // Enable every third clock, 1-cycle interval, interrupt on underflow
        ce_mode = 1;
        bus(1'b1, 7'h14, 8'h05);
        for (int k = 0; k < 40 && diag != 8'h00; k++) cycle();
        chk("t1_zero", diag, 8'h00);
        bus(1'b0, 7'h0C, 8'h00);
        for (int k = 0; k < 40 && irq_o !== 1'b1; k++) cycle();
        chk("t1_irq", {7'b0, irq_o}, 8'h01);
        bus(1'b0, 7'h04, 8'h00);

        // PA7 edge detection
        ce_mode = 0;
        bus(1'b1, 7'h17, 8'hFF);
        bus(1'b1, 7'h07, 8'h00);
        pa_i = 8'hBC;
        idle(1);
        chk("edge_irq", {7'b0, irq_o}, 8'h01);
        bus(1'b0, 7'h05, 8'h00);
        chk("edge_stat", dat_o, 8'h40);
        chk("edge_clr_irq", {7'b0, irq_o}, 8'h00);
        pa_i = 8'h3C;
        idle(1);
        pa_i = 8'hBC;
        bus(1'b0, 7'h05, 8'h00);
        chk("edge_race_rd", dat_o, 8'h00);
        chk("edge_race_irq", {7'b0, irq_o}, 8'h01);
        bus(1'b0, 7'h0D, 8'h00);
        chk("edge_race_stat", dat_o, 8'h40);

        // Load collides with an underflow tick
        bus(1'b1, 7'h14, 8'h00);
        bus(1'b1, 7'h15, 8'h10);
        chk("coll_load", diag, 8'h10);
        bus(1'b0, 7'h05, 8'h00);
        chk("coll_tflag", dat_o, 8'h00);
        idle(6);
        chk("coll_hold", diag, 8'h10);
        idle(1);
        chk("coll_tick", diag, 8'h0F);

        // Reset in the middle of a count with tflag set
        bus(1'b1, 7'h1C, 8'h00);
        idle(2);
        chk("pre_rst_irq", {7'b0, irq_o}, 8'h01);
        bus(1'b0, 7'h01, 8'h00);
        chk("pre_rst_dat", dat_o, 8'hF0);
        rst_i = 1'b1;
        bus(1'b0, 7'h00, 8'h00);
        chk("mid_rst_diag", diag, 8'h00);
        chk("mid_rst_irq", {7'b0, irq_o}, 8'h00);
        chk("mid_rst_dat", dat_o, 8'h00);
        chk("mid_rst_ddra", pa_oe, DDRA_R);
        rst_i = 1'b0;
        bus(1'b0, 7'h05, 8'h00);
        chk("post_rst_stat", dat_o, 8'h00);

        // Randomized traffic against the reference model
        ce_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] a;
            logic [6:0] mapped [20];
            mapped = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07,
                       7'h0C, 7'h0D, 7'h14, 7'h15, 7'h16, 7'h17, 7'h1C, 7'h1D,
                       7'h1E, 7'h1F, 7'h04, 7'h0C};
            rst_i = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) pa_i = 8'($urandom);
            if ($urandom_range(0, 7) == 0) pb_i = 8'($urandom);
            stb_i = 1'($urandom_range(0, 1));
            we_i  = 1'($urandom_range(0, 1));
            a = (($urandom_range(0, 3) != 0) ? mapped[$urandom_range(0, 19)] : 7'($urandom));
            adr_i = a;
            dat_i = 8'($urandom_range(0, 40));
            cycle();
        end
        rst_i = 1'b0;
        stb_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
